up_desc_queue_regs: RTL and testbench
=====================================

Name: up_desc_queue_regs

Overview:
- Next-generation user-plugin register block.
- Replaces the single-channel src/dst/size/trigger register set with NUM_CH independent channels.
- Each channel has a descriptor queue of depth FIFO_DEPTH, so software can post several transfers while the engine is busy.
- Sits behind the existing AXI word read/write adapters and drives the plugin engine through a valid/ready descriptor handshake per channel, plus an aggregated interrupt.

Parameters:
- NUM_CH, 4: number of channels (1..7).
- ADDR_WIDTH, 32: width of source/destination address registers.
- SIZE_WIDTH, 16: width of size register (bytes), must be <= 32.
- FIFO_DEPTH, 4: descriptors per channel queue, power of 2, >= 2.
- WORD_ADDR_WIDTH, 6: register word-address width.

Ports:
- ACLK  in  1  clock
- ARESET  in  1  synchronous reset, active-high
- wr_valid_i  in  1  one-cycle register write strobe from word write adapter
- wr_addr_i  in  WORD_ADDR_WIDTH  write word address
- wr_data_i  in  32  write data
- wr_strb_i  in  4  byte strobes
- rd_addr_i  in  WORD_ADDR_WIDTH  read word address
- rd_data_o  out  32  read data, combinational from rd_addr_i
- desc_valid_o  out  NUM_CH  head descriptor available, per channel
- desc_ready_i  in  NUM_CH  engine accepts head descriptor
- desc_src_o  out  NUM_CH x ADDR_WIDTH  head source address
- desc_dst_o  out  NUM_CH x ADDR_WIDTH  head destination address
- desc_size_o  out  NUM_CH x SIZE_WIDTH  head size
- engine_busy_i  in  NUM_CH  engine currently processing channel
- done_i  in  NUM_CH  one-cycle completion pulse per channel
- irq_o  out  1  OR over channels of (int_pending & int_en), registered

Behaviour:
Register map:
- Channel c occupies words c*8 + k:
  - k=0 SRC (RW, ADDR_WIDTH; bytes above bit 31 unreachable, ADDR_WIDTH > 32 not supported)
  - k=1 DST (RW)
  - k=2 SIZE (RW, SIZE_WIDTH)
  - k=3 CTRL (RW, bit0 int_en)
  - k=4 CMD (WO, reads 0)
  - k=5 STATUS (RO)
  - k=6..7 reserved, read 0
- Global words:
  - 56 IRQ_STATUS: RO bit c = int_pending of channel c.
  - 57 IRQ_CLR: write-1-clears int_pending per bit, reads 0.
- Unmapped reads return 0. Unmapped writes are ignored.
- RW registers honour byte strobes, bit i is written iff wr_strb_i[i/8].

CMD bits (each acts only if its byte strobe is set):
- bit0 clr_int: clears int_pending, overflow and size_err.
- bit1 push: enqueue {SRC,DST,SIZE} current values.
- bit2 flush: empty the queue.

STATUS bits:
- bit0 busy = (count != 0) | engine_busy_i[c]
- bit1 int_pending
- bit2 full
- bit3 empty
- bit4 overflow (sticky)
- bit5 size_err (sticky)
- bits[15:8] count

Queue:
- Push takes effect at the ACLK edge of the write; the descriptor appears at the head with desc_valid_o high the next cycle when the queue was empty.
- Pop occurs on desc_valid_o & desc_ready_i. desc_* outputs show the head entry and are stable while valid & !ready.
- Push with SIZE==0: dropped, sets size_err.
- Push when full with no pop in the same cycle: dropped, sets overflow.
- Push when full with a pop in the same cycle: accepted, count unchanged, no overflow.
- Flush and push in the same cycle: flush wins, push dropped, no flags set.
- Flush and pop in the same cycle: queue ends empty.
- Pointers wrap modulo FIFO_DEPTH. count ranges 0..FIFO_DEPTH.

Interrupts:
- done_i[c] sets int_pending[c].
- done_i and a clear (CMD clr_int or IRQ_CLR) in the same cycle: set wins.
- irq_o is registered, one cycle after int_pending/int_en change.
- int_en=0 masks irq_o only; int_pending still sets.

Reset (ARESET high at an ACLK edge):
- All registers, pointers, counts and sticky flags go to 0.
- desc_valid_o=0, irq_o=0.
- In-flight descriptors are discarded.
- Reset is honoured mid-queue regardless of engine handshake.

Decomposition:
- Package up_desc_pkg holds:
  - word offsets SRC..STATUS and CH_STRIDE=8
  - IRQ_STATUS_ADDR=56, IRQ_CLR_ADDR=57
  - CMD/STATUS bit indices
  - a descriptor struct type parametrised through localparams in the top level
- One sub-module, up_desc_fifo: synchronous FIFO with flush, ready/valid pop, full/empty/count, and push-when-full-with-pop acceptance.
- Instantiate it NUM_CH times in a generate loop.
- Register decode, sticky flags and interrupt logic stay in the top.

Test Plan:
- Reset, then read ch0 STATUS -> 0x00000008 (empty only); IRQ_STATUS -> 0; irq_o=0.
- ch1: SRC=0x1000, DST=0x2000, SIZE=0x40, CMD=0x2 with desc_ready_i=0 -> next cycle desc_valid_o[1]=1, src=0x1000, dst=0x2000, size=0x40; STATUS count=1, busy=1.
- ch0: push 5 distinct descriptors (sizes 1..5) with ready=0, FIFO_DEPTH=4 -> STATUS full=1, overflow=1, count=4. Assert ready -> pops sizes 1,2,3,4 in order, then empty=1.
- ch2: SIZE=0, push -> size_err=1, count=0. Then CMD=0x1 -> size_err=0.
- ch3: CTRL=1, done_i[3] pulse -> int_pending=1, irq_o=1 one cycle later. Write IRQ_CLR=0x8 in the same cycle as a second done_i[3] -> pending stays 1. Clear alone -> irq_o=0.
- Full queue with push and pop in the same cycle -> count stays 4, overflow=0. Flush with push in the same cycle -> count=0, no flags. Assert ARESET mid-queue -> all outputs 0 next cycle.

Source files
------------

// File: rtl/up_desc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | up_desc_pkg                                                          |
// | Register map, command/status bit positions and byte-strobe helper.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package up_desc_pkg;

    localparam int CH_STRIDE       = 8;
    localparam int IRQ_STATUS_ADDR = 56;
    localparam int IRQ_CLR_ADDR    = 57;

    localparam logic [2:0] SRC_OFS    = 3'd0;
    localparam logic [2:0] DST_OFS    = 3'd1;
    localparam logic [2:0] SIZE_OFS   = 3'd2;
    localparam logic [2:0] CTRL_OFS   = 3'd3;
    localparam logic [2:0] CMD_OFS    = 3'd4;
    localparam logic [2:0] STATUS_OFS = 3'd5;

    localparam int CMD_CLR_INT_BIT = 0;
    localparam int CMD_PUSH_BIT    = 1;
    localparam int CMD_FLUSH_BIT   = 2;

    localparam int ST_BUSY_BIT   = 0;
    localparam int ST_PEND_BIT   = 1;
    localparam int ST_FULL_BIT   = 2;
    localparam int ST_EMPTY_BIT  = 3;
    localparam int ST_OVF_BIT    = 4;
    localparam int ST_SERR_BIT   = 5;
    localparam int ST_COUNT_LSB  = 8;

    // Widest address/size a descriptor can carry through the 32-bit register port.
    localparam int MAX_ADDR_W = 32;
    localparam int MAX_SIZE_W = 32;

    function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/up_desc_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | up_desc_fifo                                                         |
// | Synchronous descriptor FIFO with flush and push-while-full-on-pop.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module up_desc_fifo #(
    parameter int DATA_W = 80,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [DATA_W-1:0]        push_data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic [DATA_W-1:0]        head_o,
    output logic                     valid_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              w_do_push;
    logic              w_do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign valid_o = !empty_o;
    assign count_o = count_q;
    // Gated so a discarded or never-written slot is not visible at the head.
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    assign w_do_pop  = pop_i && !empty_o;
    assign w_do_push = push_i && (!full_o || w_do_pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (w_do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (w_do_push && !w_do_pop)      count_d = count_q + CNT_W'(1);
            else if (!w_do_push && w_do_pop) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule
`default_nettype wire

// File: rtl/up_desc_queue_regs.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | up_desc_queue_regs                                                   |
// | Multi-channel descriptor-queue register block with aggregated IRQ.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module up_desc_queue_regs
    import up_desc_pkg::*;
#(
    parameter int NUM_CH          = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int SIZE_WIDTH      = 16,
    parameter int FIFO_DEPTH      = 4,
    parameter int WORD_ADDR_WIDTH = 6
) (
    input  logic                                  ACLK,
    input  logic                                  ARESET,
    input  logic                                  wr_valid_i,
    input  logic [WORD_ADDR_WIDTH-1:0]            wr_addr_i,
    input  logic [31:0]                           wr_data_i,
    input  logic [3:0]                            wr_strb_i,
    input  logic [WORD_ADDR_WIDTH-1:0]            rd_addr_i,
    output logic [31:0]                           rd_data_o,
    output logic [NUM_CH-1:0]                     desc_valid_o,
    input  logic [NUM_CH-1:0]                     desc_ready_i,
    output logic [NUM_CH-1:0][ADDR_WIDTH-1:0]     desc_src_o,
    output logic [NUM_CH-1:0][ADDR_WIDTH-1:0]     desc_dst_o,
    output logic [NUM_CH-1:0][SIZE_WIDTH-1:0]     desc_size_o,
    input  logic [NUM_CH-1:0]                     engine_busy_i,
    input  logic [NUM_CH-1:0]                     done_i,
    output logic                                  irq_o
);

    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int CH_W   = WORD_ADDR_WIDTH - 3;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] src;
        logic [ADDR_WIDTH-1:0] dst;
        logic [SIZE_WIDTH-1:0] size;
    } desc_t;

    localparam int DESC_W = $bits(desc_t);

    logic [NUM_CH-1:0][ADDR_WIDTH-1:0] src_q, src_d;
    logic [NUM_CH-1:0][ADDR_WIDTH-1:0] dst_q, dst_d;
    logic [NUM_CH-1:0][SIZE_WIDTH-1:0] size_q, size_d;
    logic [NUM_CH-1:0]                 int_en_q, int_en_d;
    logic [NUM_CH-1:0]                 int_pending_q, int_pending_d;
    logic [NUM_CH-1:0]                 overflow_q, overflow_d;
    logic [NUM_CH-1:0]                 size_err_q, size_err_d;
    logic                              irq_q, irq_d;

    logic [2:0]                        w_wr_ofs;
    logic [CH_W-1:0]                   w_wr_ch;
    logic [2:0]                        w_rd_ofs;
    logic [CH_W-1:0]                   w_rd_ch;
    logic                              w_irq_clr;
    logic [NUM_CH-1:0]                 w_ch_hit;
    logic [NUM_CH-1:0]                 w_push_req;
    logic [NUM_CH-1:0]                 w_push;
    logic [NUM_CH-1:0]                 w_pop;
    logic [NUM_CH-1:0]                 w_flush;
    logic [NUM_CH-1:0]                 w_clr;
    logic [NUM_CH-1:0]                 w_full;
    logic [NUM_CH-1:0]                 w_empty;
    logic [NUM_CH-1:0][CNT_W-1:0]      w_count;
    logic [NUM_CH-1:0][31:0]           w_status;

    assign w_wr_ofs  = wr_addr_i[2:0];
    assign w_wr_ch   = wr_addr_i[WORD_ADDR_WIDTH-1:3];
    assign w_rd_ofs  = rd_addr_i[2:0];
    assign w_rd_ch   = rd_addr_i[WORD_ADDR_WIDTH-1:3];
    assign w_irq_clr = wr_valid_i && (wr_addr_i == WORD_ADDR_WIDTH'(IRQ_CLR_ADDR)) && wr_strb_i[0];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        desc_t       w_tail;
        desc_t       w_head;
        logic        w_cmd;
        logic [31:0] w_st;

        assign w_ch_hit[c]   = wr_valid_i && (w_wr_ch == CH_W'(c));
        assign w_cmd         = w_ch_hit[c] && (w_wr_ofs == CMD_OFS) && wr_strb_i[0];
        assign w_flush[c]    = w_cmd && wr_data_i[CMD_FLUSH_BIT];
        // A flush in the same write cancels the push without flagging it.
        assign w_push_req[c] = w_cmd && wr_data_i[CMD_PUSH_BIT] && !wr_data_i[CMD_FLUSH_BIT];
        assign w_push[c]     = w_push_req[c] && (size_q[c] != '0);
        assign w_pop[c]      = desc_valid_o[c] && desc_ready_i[c];
        assign w_clr[c]      = (w_cmd && wr_data_i[CMD_CLR_INT_BIT]) || (w_irq_clr && wr_data_i[c]);

        assign w_tail.src  = src_q[c];
        assign w_tail.dst  = dst_q[c];
        assign w_tail.size = size_q[c];

        up_desc_fifo #(
            .DATA_W (DESC_W),
            .DEPTH  (FIFO_DEPTH)
        ) u_fifo (
            .clk         (ACLK),
            .rst         (ARESET),
            .push_i      (w_push[c]),
            .push_data_i (w_tail),
            .pop_i       (w_pop[c]),
            .flush_i     (w_flush[c]),
            .head_o      (w_head),
            .valid_o     (desc_valid_o[c]),
            .full_o      (w_full[c]),
            .empty_o     (w_empty[c]),
            .count_o     (w_count[c])
        );

        assign desc_src_o[c]  = w_head.src;
        assign desc_dst_o[c]  = w_head.dst;
        assign desc_size_o[c] = w_head.size;

        always_comb begin
            w_st                      = '0;
            w_st[ST_BUSY_BIT]         = (w_count[c] != '0) || engine_busy_i[c];
            w_st[ST_PEND_BIT]         = int_pending_q[c];
            w_st[ST_FULL_BIT]         = w_full[c];
            w_st[ST_EMPTY_BIT]        = w_empty[c];
            w_st[ST_OVF_BIT]          = overflow_q[c];
            w_st[ST_SERR_BIT]         = size_err_q[c];
            w_st[ST_COUNT_LSB +: 8]   = 8'(w_count[c]);
        end
        assign w_status[c] = w_st;
    end

    always_comb begin
        src_d         = src_q;
        dst_d         = dst_q;
        size_d        = size_q;
        int_en_d      = int_en_q;
        int_pending_d = int_pending_q;
        overflow_d    = overflow_q;
        size_err_d    = size_err_q;
        irq_d         = |(int_pending_q & int_en_q);
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_ch_hit[c] && (w_wr_ofs == SRC_OFS))
                src_d[c] = ADDR_WIDTH'(apply_strb(32'(src_q[c]), wr_data_i, wr_strb_i));
            if (w_ch_hit[c] && (w_wr_ofs == DST_OFS))
                dst_d[c] = ADDR_WIDTH'(apply_strb(32'(dst_q[c]), wr_data_i, wr_strb_i));
            if (w_ch_hit[c] && (w_wr_ofs == SIZE_OFS))
                size_d[c] = SIZE_WIDTH'(apply_strb(32'(size_q[c]), wr_data_i, wr_strb_i));
            if (w_ch_hit[c] && (w_wr_ofs == CTRL_OFS) && wr_strb_i[0])
                int_en_d[c] = wr_data_i[0];
            // Sets are ORed in after the clear so a same-cycle event is never lost.
            int_pending_d[c] = (int_pending_q[c] && !w_clr[c]) || done_i[c];
            overflow_d[c]    = (overflow_q[c] && !w_clr[c]) ||
                               (w_push[c] && w_full[c] && !w_pop[c]);
            size_err_d[c]    = (size_err_q[c] && !w_clr[c]) ||
                               (w_push_req[c] && (size_q[c] == '0));
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            src_q         <= '0;
            dst_q         <= '0;
            size_q        <= '0;
            int_en_q      <= '0;
            int_pending_q <= '0;
            overflow_q    <= '0;
            size_err_q    <= '0;
            irq_q         <= 1'b0;
        end else begin
            src_q         <= src_d;
            dst_q         <= dst_d;
            size_q        <= size_d;
            int_en_q      <= int_en_d;
            int_pending_q <= int_pending_d;
            overflow_q    <= overflow_d;
            size_err_q    <= size_err_d;
            irq_q         <= irq_d;
        end
    end

    assign irq_o = irq_q;

    always_comb begin
        rd_data_o = '0;
        if (rd_addr_i == WORD_ADDR_WIDTH'(IRQ_STATUS_ADDR))
            rd_data_o = 32'(int_pending_q);
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_rd_ch == CH_W'(c)) begin
                case (w_rd_ofs)
                    SRC_OFS:    rd_data_o = 32'(src_q[c]);
                    DST_OFS:    rd_data_o = 32'(dst_q[c]);
                    SIZE_OFS:   rd_data_o = 32'(size_q[c]);
                    CTRL_OFS:   rd_data_o = {31'b0, int_en_q[c]};
                    STATUS_OFS: rd_data_o = w_status[c];
                    default:    rd_data_o = '0;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_up_desc_queue_regs.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_up_desc_queue_regs                                                |
// | Directed self-checking bench for the descriptor-queue register block.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_up_desc_queue_regs;

    localparam int NUM_CH = 4;
    localparam int AW     = 32;
    localparam int SW     = 16;
    localparam int DEPTH  = 4;
    localparam int WAW    = 6;

    logic                          ACLK = 1'b0;
    logic                          ARESET;
    logic                          wr_valid_i;
    logic [WAW-1:0]                wr_addr_i;
    logic [31:0]                   wr_data_i;
    logic [3:0]                    wr_strb_i;
    logic [WAW-1:0]                rd_addr_i;
    logic [31:0]                   rd_data_o;
    logic [NUM_CH-1:0]             desc_valid_o;
    logic [NUM_CH-1:0]             desc_ready_i;
    logic [NUM_CH-1:0][AW-1:0]     desc_src_o;
    logic [NUM_CH-1:0][AW-1:0]     desc_dst_o;
    logic [NUM_CH-1:0][SW-1:0]     desc_size_o;
    logic [NUM_CH-1:0]             engine_busy_i;
    logic [NUM_CH-1:0]             done_i;
    logic                          irq_o;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] rd;

    up_desc_queue_regs #(
        .NUM_CH          (NUM_CH),
        .ADDR_WIDTH      (AW),
        .SIZE_WIDTH      (SW),
        .FIFO_DEPTH      (DEPTH),
        .WORD_ADDR_WIDTH (WAW)
    ) dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .wr_valid_i    (wr_valid_i),
        .wr_addr_i     (wr_addr_i),
        .wr_data_i     (wr_data_i),
        .wr_strb_i     (wr_strb_i),
        .rd_addr_i     (rd_addr_i),
        .rd_data_o     (rd_data_o),
        .desc_valid_o  (desc_valid_o),
        .desc_ready_i  (desc_ready_i),
        .desc_src_o    (desc_src_o),
        .desc_dst_o    (desc_dst_o),
        .desc_size_o   (desc_size_o),
        .engine_busy_i (engine_busy_i),
        .done_i        (done_i),
        .irq_o         (irq_o)
    );

    always #5 ACLK = ~ACLK;

    task automatic step(input int n);
        repeat (n) @(posedge ACLK);
        #1;
    endtask

    task automatic wr(input logic [WAW-1:0] a, input logic [31:0] d, input logic [3:0] s);
        wr_valid_i = 1'b1;
        wr_addr_i  = a;
        wr_data_i  = d;
        wr_strb_i  = s;
        step(1);
        wr_valid_i = 1'b0;
    endtask

    task automatic rdreg(input logic [WAW-1:0] a, output logic [31:0] d);
        rd_addr_i = a;
        #1;
        d = rd_data_o;
    endtask

    task automatic test_reset();
        rdreg(6'd5, rd);
        n_checks++; if (rd !== 32'h0000_0008) $display("FAIL reset_status0: got %h want %h", rd, 32'h8); else n_pass++;
        rdreg(6'd56, rd);
        n_checks++; if (rd !== 32'h0) $display("FAIL reset_irq_status: got %h want %h", rd, 32'h0); else n_pass++;
        n_checks++; if ({irq_o, desc_valid_o} !== 5'b0) $display("FAIL reset_outputs: got %b want %b", {irq_o, desc_valid_o}, 5'b0); else n_pass++;
    endtask

    task automatic test_single_push();
        wr(6'd8,  32'h1000, 4'hF);
        wr(6'd9,  32'h2000, 4'hF);
        wr(6'd10, 32'h40,   4'hF);
        wr(6'd12, 32'h2,    4'hF);
        n_checks++;
        if ({desc_valid_o[1], desc_src_o[1], desc_dst_o[1], desc_size_o[1]} !== {1'b1, 32'h1000, 32'h2000, 16'h40})
            $display("FAIL ch1_head: got v=%b s=%h d=%h z=%h want v=1 s=1000 d=2000 z=40",
                     desc_valid_o[1], desc_src_o[1], desc_dst_o[1], desc_size_o[1]);
        else n_pass++;
        rdreg(6'd13, rd);
        n_checks++; if (rd !== 32'h0000_0101) $display("FAIL ch1_status: got %h want %h", rd, 32'h101); else n_pass++;
        // Byte-strobe write to SRC: bytes 0 and 2 only.
        wr(6'd8, 32'hAABBCCDD, 4'b0101);
        rdreg(6'd8, rd);
        n_checks++; if (rd !== 32'h00BB10DD) $display("FAIL ch1_src_strb: got %h want %h", rd, 32'h00BB10DD); else n_pass++;
        n_checks++; if (desc_src_o[1] !== 32'h1000) $display("FAIL ch1_head_stable: got %h want %h", desc_src_o[1], 32'h1000); else n_pass++;
        rdreg(6'd12, rd);
        n_checks++; if (rd !== 32'h0) $display("FAIL ch1_cmd_read: got %h want %h", rd, 32'h0); else n_pass++;
        rdreg(6'd62, rd);
        n_checks++; if (rd !== 32'h0) $display("FAIL unmapped_read: got %h want %h", rd, 32'h0); else n_pass++;
        desc_ready_i = 4'b0010;
        step(1);
        desc_ready_i = 4'b0000;
        n_checks++; if (desc_valid_o[1] !== 1'b0) $display("FAIL ch1_pop: got %b want %b", desc_valid_o[1], 1'b0); else n_pass++;
        engine_busy_i = 4'b0010;
        rdreg(6'd13, rd);
        n_checks++; if (rd !== 32'h0000_0009) $display("FAIL ch1_engine_busy: got %h want %h", rd, 32'h9); else n_pass++;
        engine_busy_i = 4'b0000;
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 5; i++) begin
            wr(6'd0, 32'h100 * i, 4'hF);
            wr(6'd1, 32'h200 * i, 4'hF);
            wr(6'd2, i,           4'hF);
            wr(6'd4, 32'h2,       4'hF);
        end
        rdreg(6'd5, rd);
        n_checks++; if (rd !== 32'h0000_0415) $display("FAIL ch0_overflow_status: got %h want %h", rd, 32'h415); else n_pass++;
        desc_ready_i = 4'b0001;
        for (int i = 1; i <= 4; i++) begin
            n_checks++;
            if ({desc_valid_o[0], desc_src_o[0], desc_dst_o[0], desc_size_o[0]} !== {1'b1, 32'h100 * i, 32'h200 * i, 16'(i)})
                $display("FAIL ch0_pop_order%0d: got v=%b s=%h d=%h z=%h want v=1 s=%h d=%h z=%h", i,
                         desc_valid_o[0], desc_src_o[0], desc_dst_o[0], desc_size_o[0], 32'h100 * i, 32'h200 * i, i);
            else n_pass++;
            step(1);
        end
        desc_ready_i = 4'b0000;
        rdreg(6'd5, rd);
        n_checks++; if (rd !== 32'h0000_0018) $display("FAIL ch0_drained: got %h want %h", rd, 32'h18); else n_pass++;
        wr(6'd4, 32'h1, 4'hF);
        rdreg(6'd5, rd);
        n_checks++; if (rd !== 32'h0000_0008) $display("FAIL ch0_clr_flags: got %h want %h", rd, 32'h8); else n_pass++;
    endtask

    task automatic test_size_err();
        wr(6'd18, 32'h0, 4'hF);
        wr(6'd20, 32'h2, 4'hF);
        rdreg(6'd21, rd);
        n_checks++; if (rd !== 32'h0000_0028) $display("FAIL ch2_size_err: got %h want %h", rd, 32'h28); else n_pass++;
        n_checks++; if (desc_valid_o[2] !== 1'b0) $display("FAIL ch2_no_valid: got %b want %b", desc_valid_o[2], 1'b0); else n_pass++;
        wr(6'd20, 32'h1, 4'hF);
        rdreg(6'd21, rd);
        n_checks++; if (rd !== 32'h0000_0008) $display("FAIL ch2_size_err_clr: got %h want %h", rd, 32'h8); else n_pass++;
    endtask

    task automatic test_irq();
        wr(6'd27, 32'h1, 4'hF);
        done_i = 4'h8;
        step(1);
        done_i = 4'h0;
        n_checks++; if (irq_o !== 1'b0) $display("FAIL irq_latency0: got %b want %b", irq_o, 1'b0); else n_pass++;
        step(1);
        n_checks++; if (irq_o !== 1'b1) $display("FAIL irq_latency1: got %b want %b", irq_o, 1'b1); else n_pass++;
        rdreg(6'd29, rd);
        n_checks++; if (rd !== 32'h0000_000A) $display("FAIL ch3_status_pend: got %h want %h", rd, 32'hA); else n_pass++;
        wr_valid_i = 1'b1; wr_addr_i = 6'd57; wr_data_i = 32'h8; wr_strb_i = 4'hF;
        done_i = 4'h8;
        step(1);
        wr_valid_i = 1'b0;
        done_i = 4'h0;
        rdreg(6'd56, rd);
        n_checks++; if (rd !== 32'h8) $display("FAIL irq_set_wins: got %h want %h", rd, 32'h8); else n_pass++;
        wr(6'd57, 32'h8, 4'hF);
        rdreg(6'd56, rd);
        n_checks++; if (rd !== 32'h0) $display("FAIL irq_clear: got %h want %h", rd, 32'h0); else n_pass++;
        step(1);
        n_checks++; if (irq_o !== 1'b0) $display("FAIL irq_deassert: got %b want %b", irq_o, 1'b0); else n_pass++;
        wr(6'd27, 32'h0, 4'hF);
        done_i = 4'h8;
        step(1);
        done_i = 4'h0;
        step(2);
        n_checks++; if (irq_o !== 1'b0) $display("FAIL irq_masked: got %b want %b", irq_o, 1'b0); else n_pass++;
        rdreg(6'd56, rd);
        n_checks++; if (rd !== 32'h8) $display("FAIL irq_masked_pending: got %h want %h", rd, 32'h8); else n_pass++;
        wr(6'd57, 32'h8, 4'hF);
    endtask

    task automatic test_back_to_back();
        // ch0 registers still hold src=0x500 dst=0xA00 size=5.
        for (int i = 0; i < 4; i++) wr(6'd4, 32'h2, 4'hF);
        rdreg(6'd5, rd);
        n_checks++; if (rd !== 32'h0000_0405) $display("FAIL ch0_full: got %h want %h", rd, 32'h405); else n_pass++;
        wr(6'd2, 32'h9, 4'hF);
        desc_ready_i = 4'b0001;
        wr(6'd4, 32'h2, 4'hF);
        desc_ready_i = 4'b0000;
        rdreg(6'd5, rd);
        n_checks++; if (rd !== 32'h0000_0405) $display("FAIL ch0_push_pop_full: got %h want %h", rd, 32'h405); else n_pass++;
        n_checks++; if (desc_size_o[0] !== 16'h5) $display("FAIL ch0_head_after_pp: got %h want %h", desc_size_o[0], 16'h5); else n_pass++;
        wr(6'd4, 32'h6, 4'hF);
        rdreg(6'd5, rd);
        n_checks++; if (rd !== 32'h0000_0008) $display("FAIL ch0_flush_push: got %h want %h", rd, 32'h8); else n_pass++;
    endtask

    task automatic test_reset_mid_queue();
        wr(6'd4, 32'h2, 4'hF);
        wr(6'd4, 32'h2, 4'hF);
        wr(6'd27, 32'h1, 4'hF);
        done_i = 4'h8;
        step(1);
        done_i = 4'h0;
        step(1);
        n_checks++; if ({irq_o, desc_valid_o[0]} !== 2'b11) $display("FAIL pre_reset_state: got %b want %b", {irq_o, desc_valid_o[0]}, 2'b11); else n_pass++;
        ARESET = 1'b1;
        step(1);
        n_checks++;
        if ({irq_o, desc_valid_o, desc_src_o, desc_dst_o, desc_size_o} !== '0)
            $display("FAIL reset_mid_queue: got irq=%b v=%b s=%h z=%h want all 0", irq_o, desc_valid_o, desc_src_o, desc_size_o);
        else n_pass++;
        ARESET = 1'b0;
        rdreg(6'd5, rd);
        n_checks++; if (rd !== 32'h0000_0008) $display("FAIL post_reset_status0: got %h want %h", rd, 32'h8); else n_pass++;
        rdreg(6'd0, rd);
        n_checks++; if (rd !== 32'h0) $display("FAIL post_reset_src0: got %h want %h", rd, 32'h0); else n_pass++;
        rdreg(6'd56, rd);
        n_checks++; if (rd !== 32'h0) $display("FAIL post_reset_irq_status: got %h want %h", rd, 32'h0); else n_pass++;
    endtask

    initial begin
        ARESET        = 1'b1;
        wr_valid_i    = 1'b0;
        wr_addr_i     = '0;
        wr_data_i     = '0;
        wr_strb_i     = '0;
        rd_addr_i     = '0;
        desc_ready_i  = '0;
        engine_busy_i = '0;
        done_i        = '0;
        step(3);
        ARESET = 1'b0;
        test_reset();
        test_single_push();
        test_overflow();
        test_size_err();
        test_irq();
        test_back_to_back();
        test_reset_mid_queue();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
